// File: rtl/imem_pkg.sv
// Shared constants, response-owner encoding and sizing helper for the
// instruction-memory arbiter.
package imem_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 128;
  localparam int unsigned MAX_WAIT_DEFAULT  = 8;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Who owns the response slot in the cycle after an acceptance
  typedef enum logic [2:0] {
    NONE  = 3'd0,
    F_OK  = 3'd1,
    F_NOP = 3'd2,
    L_RD  = 3'd3,
    L_WR  = 3'd4,
    L_ERR = 3'd5
  } resp_owner_t;

  function automatic int unsigned word_idx_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; force_f hands the
// next grant to fetch once the limit is reached.
module imem_starve_ctr
  import imem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic force_f
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (clr) begin
      wait_cnt <= 8'd0;
    end else if (inc && (wait_cnt != LIMIT)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign force_f = (wait_cnt == LIMIT);

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-port 1-cycle BRAM: fetch (read-only)
// and loader (read/write), loader-first with fetch anti-starvation.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int unsigned MAX_WAIT  = MAX_WAIT_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
  localparam int unsigned AW = word_idx_w(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_valid,
  input  logic [31:0]   f_addr,
  output logic          f_ready,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  input  logic          l_valid,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_ready,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          l_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  logic        force_f;
  logic        f_grant;
  logic        l_grant;
  logic        f_in_range;
  logic        l_legal;
  logic        unused_bits;
  resp_owner_t resp_owner;
  resp_owner_t next_owner;

  assign unused_bits = ^f_addr[1:0];

  assign f_in_range = (f_addr[31:2] < WORD_LIMIT);
  assign l_legal    = (l_addr[31:2] < WORD_LIMIT) && (l_addr[1:0] == 2'b00);

  imem_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (f_valid && !f_grant),
    .clr    (f_grant || !f_valid),
    .force_f(force_f)
  );

  // Grant, memory drive and the response owner for the accepted request
  always_comb begin
    f_grant    = 1'b0;
    l_grant    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = l_addr[AW+1:2];
    mem_wdata  = l_wdata;
    next_owner = NONE;
    if (rst_n) begin
      f_grant = f_valid && (!l_valid || force_f);
      l_grant = l_valid && !f_grant;
      if (f_grant) begin
        mem_addr   = f_addr[AW+1:2];
        mem_en     = f_in_range;
        next_owner = f_in_range ? F_OK : F_NOP;
      end else if (l_grant) begin
        mem_en     = l_legal;
        mem_we     = l_we;
        next_owner = !l_legal ? L_ERR : (l_we ? L_WR : L_RD);
      end
    end
  end

  assign f_ready = f_grant;
  assign l_ready = l_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_owner <= NONE;
    end else begin
      resp_owner <= next_owner;
    end
  end

  // Response decode; masked while in reset so a dropped response never shows
  always_comb begin
    f_rvalid = 1'b0;
    f_rdata  = 32'd0;
    l_rvalid = 1'b0;
    l_rdata  = 32'd0;
    l_err    = 1'b0;
    if (rst_n) begin
      unique case (resp_owner)
        F_OK: begin
          f_rvalid = 1'b1;
          f_rdata  = mem_rdata;
        end
        F_NOP: begin
          f_rvalid = 1'b1;
          f_rdata  = NOP_INSTR;
        end
        L_RD: begin
          l_rvalid = 1'b1;
          l_rdata  = mem_rdata;
        end
        L_WR: begin
          l_rvalid = 1'b1;
        end
        L_ERR: begin
          l_rvalid = 1'b1;
          l_err    = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter with a behavioural 1-cycle BRAM
// preloaded with 32'hA000_0000 | word.
module tb_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        f_valid;
  logic [31:0] f_addr;
  logic        f_ready;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        l_valid;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_ready;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic        l_err;
  logic        mem_en;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] bram [128];
  int tests_run;
  int tests_failed;

  imem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_valid  (f_valid),
    .f_addr   (f_addr),
    .f_ready  (f_ready),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .l_valid  (l_valid),
    .l_we     (l_we),
    .l_addr   (l_addr),
    .l_wdata  (l_wdata),
    .l_ready  (l_ready),
    .l_rvalid (l_rvalid),
    .l_rdata  (l_rdata),
    .l_err    (l_err),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bram[mem_addr];
    end
  end

  task automatic test_reset;
    rst_n   = 1'b0;
    f_valid = 1'b1;
    f_addr  = 32'h10;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (f_ready !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_f_ready[%0d]: got %b want 0", i, f_ready);
      end
      tests_run++;
      if (mem_en !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_mem_en[%0d]: got %b want 0", i, mem_en);
      end
      tests_run++;
      if ({f_rvalid, l_rvalid, l_err, f_rdata, l_rdata} !== 67'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs[%0d]: got %b/%b/%b %h %h want zeros", i, f_rvalid, l_rvalid, l_err, f_rdata, l_rdata);
      end
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (f_ready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 7'd4) begin
      tests_failed++;
      $display("[TB] FAIL first_grant: got ready=%b en=%b addr=%0d want 1 1 4", f_ready, mem_en, mem_addr);
    end
    @(negedge clk);
    f_valid = 1'b0;
    tests_run++;
    if (f_rvalid !== 1'b1 || f_rdata !== 32'hA000_0004) begin
      tests_failed++;
      $display("[TB] FAIL first_resp: got %b %h want 1 a0000004", f_rvalid, f_rdata);
    end
  endtask

  task automatic test_write_then_fetch;
    @(negedge clk);
    l_valid = 1'b1;
    l_we    = 1'b1;
    l_addr  = 32'h8;
    l_wdata = 32'h07b0_0093;
    #1;
    tests_run++;
    if (l_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 7'd2 || mem_wdata !== 32'h07b0_0093) begin
      tests_failed++;
      $display("[TB] FAIL wr_grant: got rdy=%b en=%b we=%b addr=%0d wd=%h want 1 1 1 2 07b00093", l_ready, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    tests_run++;
    if (l_rvalid !== 1'b1 || l_err !== 1'b0 || l_rdata !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL wr_ack: got rv=%b err=%b rd=%h want 1 0 0", l_rvalid, l_err, l_rdata);
    end
    l_valid = 1'b0;
    l_we    = 1'b0;
    f_valid = 1'b1;
    f_addr  = 32'h8;
    #1;
    tests_run++;
    if (f_ready !== 1'b1 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fetch_after_wr_grant: got rdy=%b we=%b want 1 0", f_ready, mem_we);
    end
    @(negedge clk);
    f_valid = 1'b0;
    tests_run++;
    if (f_rvalid !== 1'b1 || f_rdata !== 32'h07b0_0093) begin
      tests_failed++;
      $display("[TB] FAIL fetch_after_wr_data: got %b %h want 1 07b00093", f_rvalid, f_rdata);
    end
  endtask

  task automatic test_starvation;
    logic exp_f;
    for (int i = 0; i <= 18; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_f = ((i - 1) % 9 == 8);
        tests_run++;
        if (f_rvalid !== exp_f || l_rvalid !== !exp_f) begin
          tests_failed++;
          $display("[TB] FAIL starve_resp[%0d]: got f=%b l=%b want f=%b l=%b", i - 1, f_rvalid, l_rvalid, exp_f, !exp_f);
        end
        tests_run++;
        if (exp_f ? (f_rdata !== 32'hA000_0003) : (l_rdata !== 32'hA000_0004)) begin
          tests_failed++;
          $display("[TB] FAIL starve_data[%0d]: got f=%h l=%h want %h", i - 1, f_rdata, l_rdata, exp_f ? 32'hA000_0003 : 32'hA000_0004);
        end
      end
      if (i == 0) begin
        f_valid = 1'b1;
        f_addr  = 32'hC;
        l_valid = 1'b1;
        l_we    = 1'b0;
        l_addr  = 32'h10;
      end
      if (i == 18) begin
        f_valid = 1'b0;
        l_valid = 1'b0;
      end else begin
        #1;
        exp_f = (i % 9 == 8);
        tests_run++;
        if (f_ready !== exp_f || l_ready !== !exp_f) begin
          tests_failed++;
          $display("[TB] FAIL starve_grant[%0d]: got f=%b l=%b want f=%b l=%b", i, f_ready, l_ready, exp_f, !exp_f);
        end
      end
    end
  endtask

  task automatic test_errors;
    @(negedge clk);
    l_valid = 1'b1;
    l_we    = 1'b0;
    l_addr  = 32'h6;
    #1;
    tests_run++;
    if (l_ready !== 1'b1 || mem_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL misalign_grant: got rdy=%b en=%b want 1 0", l_ready, mem_en);
    end
    @(negedge clk);
    tests_run++;
    if (l_rvalid !== 1'b1 || l_err !== 1'b1 || l_rdata !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL misalign_resp: got rv=%b err=%b rd=%h want 1 1 0", l_rvalid, l_err, l_rdata);
    end
    l_we    = 1'b1;
    l_addr  = 32'h200;
    l_wdata = 32'hDEAD_BEEF;
    #1;
    tests_run++;
    if (l_ready !== 1'b1 || mem_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL oor_l_grant: got rdy=%b en=%b want 1 0", l_ready, mem_en);
    end
    @(negedge clk);
    tests_run++;
    if (l_rvalid !== 1'b1 || l_err !== 1'b1 || l_rdata !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL oor_l_resp: got rv=%b err=%b rd=%h want 1 1 0", l_rvalid, l_err, l_rdata);
    end
    l_valid = 1'b0;
    l_we    = 1'b0;
    f_valid = 1'b1;
    f_addr  = 32'h200;
    #1;
    tests_run++;
    if (f_ready !== 1'b1 || mem_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL oor_f_grant: got rdy=%b en=%b want 1 0", f_ready, mem_en);
    end
    @(negedge clk);
    f_valid = 1'b0;
    tests_run++;
    if (f_rvalid !== 1'b1 || f_rdata !== 32'h0000_0013 || l_rvalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL oor_f_resp: got rv=%b rd=%h lrv=%b want 1 00000013 0", f_rvalid, f_rdata, l_rvalid);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    f_valid = 1'b1;
    f_addr  = 32'h4;
    #1;
    tests_run++;
    if (f_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_accept: got %b want 1", f_ready);
    end
    @(negedge clk);
    f_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    tests_run++;
    if (f_rvalid !== 1'b0 || f_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_in_reset: got rv=%b rdy=%b want 0 0", f_rvalid, f_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (f_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL mid_stale[%0d]: got f=%b l=%b want 0 0", i, f_rvalid, l_rvalid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_data [4];
    exp_data[0] = 32'hA000_0000;
    exp_data[1] = 32'hA000_0001;
    exp_data[2] = 32'h07b0_0093;
    exp_data[3] = 32'hA000_0003;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests_run++;
        if (f_rvalid !== 1'b1 || f_rdata !== exp_data[i-1]) begin
          tests_failed++;
          $display("[TB] FAIL b2b_resp[%0d]: got %b %h want 1 %h", i - 1, f_rvalid, f_rdata, exp_data[i-1]);
        end
      end
      if (i < 4) begin
        f_valid = 1'b1;
        f_addr  = 32'(i * 4);
        #1;
        tests_run++;
        if (f_ready !== 1'b1 || mem_addr !== 7'(i)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_grant[%0d]: got rdy=%b addr=%0d want 1 %0d", i, f_ready, mem_addr, i);
        end
      end else begin
        f_valid = 1'b0;
      end
    end
    @(negedge clk);
    tests_run++;
    if (f_rvalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_tail: got %b want 0", f_rvalid);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    mem_rdata    = 32'd0;
    for (int i = 0; i < 128; i++) bram[i] = 32'hA000_0000 | 32'(i);
    rst_n   = 1'b0;
    f_valid = 1'b0;
    f_addr  = 32'd0;
    l_valid = 1'b0;
    l_we    = 1'b0;
    l_addr  = 32'd0;
    l_wdata = 32'd0;
    test_reset();
    test_write_then_fetch();
    test_starvation();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Shares the single-port, 1-cycle-latency instruction memory between two requesters.
- Port F is the CPU fetch, read-only.
- Port L is the program loader or debug port, read/write.
- Sits between the fetch stage, the loader, and the imem BRAM. It issues at most one memory access per cycle and returns the response exactly one cycle later on the winning port.
- Includes anti-starvation so a busy loader cannot stall fetch indefinitely.

Parameters:
- MEM_WORDS, 128: memory depth in 32-bit words. Must be a power of 2.
- MAX_WAIT, 8: consecutive cycles fetch may be denied before it is forced to win. Range 1..255.
- NOP_INSTR, 32'h00000013: data returned to fetch for out-of-range addresses.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset. Synchronous, active-low.
- f_valid  in  1  fetch request.
- f_addr  in  32  fetch byte address. Bits [1:0] are ignored.
- f_ready  out  1  fetch request accepted this cycle. Combinational.
- f_rvalid  out  1  fetch response valid, one-cycle pulse.
- f_rdata  out  32  fetch response instruction.
- l_valid  in  1  loader request.
- l_we  in  1  1 = write, 0 = read.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  write data.
- l_ready  out  1  loader request accepted. Combinational.
- l_rvalid  out  1  loader response or write-ack pulse.
- l_rdata  out  32  loader read data; 0 for writes and errors.
- l_err  out  1  qualifies l_rvalid: misaligned or out-of-range access.
- mem_en  out  1  BRAM access strobe.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  log2(MEM_WORDS)  word index.
- mem_wdata  out  32  BRAM write data.
- mem_rdata  in  32  BRAM read data. Valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - Registered outputs and state clear: f_rvalid=0, l_rvalid=0, l_err=0, f_rdata=0, l_rdata=0, wait_cnt=0, resp_owner=NONE.
  - Combinational outputs f_ready, l_ready, mem_en and mem_we are also forced to 0 while rst_n=0.
  - A response pending when reset asserts is dropped and never delivered.
- Arbitration, per cycle:
  - Default priority is L over F.
  - F wins if l_valid=0, or if wait_cnt==MAX_WAIT.
  - Exactly one of f_ready/l_ready is high when any valid is high; neither is high otherwise.
  - A request is accepted when valid & ready. The requester must hold its address and data stable until accepted.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, on any cycle where f_valid=1 and f_ready=0.
  - Clears on an F grant, or when f_valid=0.
- Address decode:
  - word = addr[31:2].
  - In range iff word < MEM_WORDS.
  - An L access is misaligned iff l_addr[1:0] != 0.
- Memory drive on the grant cycle:
  - mem_en=1 only for legal accesses.
  - mem_addr = word[log2(MEM_WORDS)-1:0].
  - mem_we = l_we for an L grant, 0 for an F grant.
  - mem_wdata = l_wdata.
  - Illegal accesses are still accepted but produce no memory access (mem_en=0).
- Responses (exactly 1-cycle latency after acceptance):
  - Legal F read: f_rvalid=1, f_rdata=mem_rdata.
  - Out-of-range F read: f_rvalid=1, f_rdata=NOP_INSTR.
  - Legal L read: l_rvalid=1, l_rdata=mem_rdata, l_err=0.
  - Legal L write: l_rvalid=1, l_rdata=0, l_err=0. The write completes in the BRAM on the grant edge.
  - Illegal L access: l_rvalid=1, l_rdata=0, l_err=1.
- State:
  - resp_owner ∈ {NONE, F_OK, F_NOP, L_RD, L_WR, L_ERR} is registered at acceptance and decoded in the next cycle.
  - rvalid outputs are single-cycle pulses.
- Pipelining:
  - Back-to-back acceptances every cycle are legal. Throughput is one access per cycle, with no bubbles.
- Hazards:
  - An L write to word W followed next cycle by an F read of W must return the new data. This holds naturally through BRAM write-then-read ordering and must not be bypassed.

Decomposition:
- Package imem_pkg holds:
  - NOP_INSTR constant.
  - MEM_WORDS default.
  - resp_owner enum encoding.
  - Word-index width function (clog2).
- Sub-module imem_starve_ctr contains the saturating wait_cnt with inputs {inc, clr} and output force_f.
- The arbiter, decode and response registers stay in imem_arbiter.

Test Plan:
1. Reset sequencing:
   - Assert rst_n=0 for 2 cycles while f_valid=1 → f_ready=0 and mem_en=0 throughout.
   - Deassert → the first grant goes to F; f_rvalid rises on the next cycle with mem_rdata.
2. Loader write then fetch:
   - l_valid, l_we=1, l_addr=0x8, l_wdata=0x07b00093 accepted.
   - Next cycle: F reads 0x8 → f_rdata=0x07b00093 one cycle after acceptance; l_rvalid=1, l_err=0 on the write-ack cycle.
3. Contention and starvation (MAX_WAIT=8):
   - l_valid and f_valid held high continuously.
   - L wins 8 consecutive cycles, F is granted on the 9th, then L resumes. Pattern repeats with period 9.
4. Error paths:
   - l_addr=0x6 → l_rvalid=1, l_err=1, mem_en=0.
   - l_addr=0x200 (word 128) → l_err=1.
   - f_addr=0x200 → f_rdata=0x00000013.
5. Reset mid-operation:
   - Accept an F read, then assert rst_n=0 on the next edge → f_rvalid stays 0 and no stale response appears after reset release.
6. Back-to-back:
   - F reads 0x0, 0x4, 0x8, 0xC on consecutive cycles with l_valid=0 → four consecutive f_rvalid pulses with matching data, no gaps.
